test_sequencer: RTL

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_seq_pkg.sv | 28 ++
 rtl/test_seq_src_track.sv | 57 +++++
 rtl/test_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/test_seq_pkg.sv
// Shared definitions for the test sequencer.
//   seq_state_e  : sequencer FSM states (HOLD, RUN, END, DONE)
//   seq_status_e : encoding of the status output (running/pass/fail/timeout)
//   HOLD_CNT_W   : width of the hold-phase counter (covers HOLD_CYC up to 255)
//   idx_width()  : width of a source index, never less than one bit
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        STATUS_RUNNING = 2'd0,
        STATUS_PASS    = 2'd1,
        STATUS_FAIL    = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } seq_status_e;

    localparam int HOLD_CNT_W = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/test_seq_src_track.sv
// Per-source result tracking for the test sequencer.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   track_en     : high while the test is running; seen bits only update then
//   src_success  : per-source success pulse/level
//   src_fail     : per-source failure pulse/level
//   all_seen     : every source has reported success, counting this cycle's inputs
//   any_fail     : at least one source reports failure this cycle
//   fail_idx     : lowest index among the sources reporting failure this cycle
module test_seq_src_track
    import test_seq_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int IDX_W = idx_width(N_SRC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             track_en,
    input  logic [N_SRC-1:0] src_success,
    input  logic [N_SRC-1:0] src_fail,
    output logic             all_seen,
    output logic             any_fail,
    output logic [IDX_W-1:0] fail_idx
);

    logic [N_SRC-1:0] seen_d;
    logic [N_SRC-1:0] seen_q;

    always_comb begin
        seen_d = seen_q;
        if (track_en) begin
            seen_d = seen_q | src_success;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end

    // Pass may be declared in the same cycle the last success arrives.
    assign all_seen = &(seen_q | src_success);
    assign any_fail = |src_fail;

    // Scanning from the top down lets the lowest set index win.
    always_comb begin
        fail_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_fail[i]) begin
                fail_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: holds the harness in reset for HOLD_CYC cycles, runs the
// test while counting cycles, decides pass / fail / timeout from the reporting
// sources, then handshakes end-of-test with the testbench.
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   cfg_max_cycles : timeout limit (0 = none), captured when RUN begins
//   src_success    : per-source success inputs
//   src_fail       : per-source failure inputs
//   finish_ack     : end-of-test acknowledge, honoured only in END
//   dut_reset      : active-high reset to the harness
//   cycle_count    : cycles spent in RUN (saturating)
//   status         : 0 running, 1 pass, 2 fail, 3 timeout
//   fail_src       : index of the failing source
//   finish_req     : end-of-test request, high throughout END
// All outputs come straight from flops.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int CNT_W    = 64,
    parameter int HOLD_CYC = 8,
    localparam int IDX_W   = idx_width(N_SRC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    input  logic [N_SRC-1:0] src_success,
    input  logic [N_SRC-1:0] src_fail,
    input  logic             finish_ack,
    output logic             dut_reset,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       status,
    output logic [IDX_W-1:0] fail_src,
    output logic             finish_req
);

    seq_state_e            state_d,      state_q;
    logic [HOLD_CNT_W-1:0] hold_d,       hold_q;
    logic [CNT_W-1:0]      count_d,      count_q;
    logic [CNT_W-1:0]      limit_d,      limit_q;
    seq_status_e           status_d,     status_q;
    logic [IDX_W-1:0]      fail_src_d,   fail_src_q;
    logic                  finish_req_d, finish_req_q;
    logic                  dut_reset_d,  dut_reset_q;

    logic             all_seen;
    logic             any_fail;
    logic [IDX_W-1:0] fail_idx;
    logic             timeout_hit;

    test_seq_src_track #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_src_track (
        .clock       (clock),
        .reset       (reset),
        .track_en    (state_q == ST_RUN),
        .src_success (src_success),
        .src_fail    (src_fail),
        .all_seen    (all_seen),
        .any_fail    (any_fail),
        .fail_idx    (fail_idx)
    );

    assign timeout_hit = (limit_q != '0) && (count_q == limit_q);

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves a value unassigned
        // and no latch is inferred.
        state_d      = state_q;
        hold_d       = hold_q;
        count_d      = count_q;
        limit_d      = limit_q;
        status_d     = status_q;
        fail_src_d   = fail_src_q;
        finish_req_d = finish_req_q;
        dut_reset_d  = dut_reset_q;

        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q + HOLD_CNT_W'(1);
                if (hold_q == HOLD_CNT_W'(HOLD_CYC - 1)) begin
                    state_d     = ST_RUN;
                    dut_reset_d = 1'b0;
                    limit_d     = cfg_max_cycles;
                end
            end

            ST_RUN: begin
                // The exit edge is a RUN cycle too, so the frozen count equals
                // the number of cycles spent in RUN.
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                // Priority: fail, then timeout, then pass.
                if (any_fail) begin
                    state_d      = ST_END;
                    status_d     = STATUS_FAIL;
                    fail_src_d   = fail_idx;
                    finish_req_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d      = ST_END;
                    status_d     = STATUS_TIMEOUT;
                    finish_req_d = 1'b1;
                end else if (all_seen) begin
                    state_d      = ST_END;
                    status_d     = STATUS_PASS;
                    finish_req_d = 1'b1;
                end
            end

            ST_END: begin
                if (finish_ack) begin
                    state_d      = ST_DONE;
                    finish_req_d = 1'b0;
                end
            end

            ST_DONE: begin
                // Terminal until reset.
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every flop samples the pre-edge values.
        if (!reset) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            count_q      <= '0;
            limit_q      <= '0;
            status_q     <= STATUS_RUNNING;
            fail_src_q   <= '0;
            finish_req_q <= 1'b0;
            dut_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
            status_q     <= status_d;
            fail_src_q   <= fail_src_d;
            finish_req_q <= finish_req_d;
            dut_reset_q  <= dut_reset_d;
        end
    end

    assign dut_reset   = dut_reset_q;
    assign cycle_count = count_q;
    assign status      = status_q;
    assign fail_src    = fail_src_q;
    assign finish_req  = finish_req_q;

endmodule
